// File: rtl/riscv_regfile_2w2r.sv
// Dual-write, dual-read integer register file with optional same-cycle
// bypass and a post-reset clear sequencer gating issue via o_regfile_ready.
module riscv_regfile_2w2r #(
    parameter int XLEN           = 32,
    parameter int NREG           = 32,
    parameter bit BYPASS         = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_regfile_rd0_wen,
    input  logic [4:0]      i_regfile_rd0_addr,
    input  logic [XLEN-1:0] i_regfile_rd0_data,
    input  logic            i_regfile_rd1_wen,
    input  logic [4:0]      i_regfile_rd1_addr,
    input  logic [XLEN-1:0] i_regfile_rd1_data,
    input  logic [4:0]      i_regfile_rs1_addr,
    input  logic [4:0]      i_regfile_rs2_addr,
    output logic [XLEN-1:0] o_regfile_rs1_data,
    output logic [XLEN-1:0] o_regfile_rs2_data,
    output logic            o_regfile_ready
);

    localparam int AW = $clog2(NREG);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            clr_we;
    logic            wr_ok;
    logic            we0, we1;
    logic [XLEN-1:0] regs_q [1:NREG-1];

    function automatic logic in_range(input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < NREG);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
            clr_cnt_q <= AW'(1);
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                clr_we    = ~i_rst;
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(NREG - 1)) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                state_d = S_READY;
            end
        endcase
    end

    assign wr_ok = (state_q == S_READY) && !i_rst;
    assign we0   = wr_ok && i_regfile_rd0_wen && in_range(i_regfile_rd0_addr);
    assign we1   = wr_ok && i_regfile_rd1_wen && in_range(i_regfile_rd1_addr);

    // Clear and architectural writes never overlap: one needs CLEAR, the other READY.
    always_ff @(posedge i_clk) begin
        for (int i = 1; i < NREG; i++) begin
            if (clr_we && clr_cnt_q == AW'(i)) begin
                regs_q[i] <= '0;
            end else if (we1 && i_regfile_rd1_addr[AW-1:0] == AW'(i)) begin
                regs_q[i] <= i_regfile_rd1_data;
            end else if (we0 && i_regfile_rd0_addr[AW-1:0] == AW'(i)) begin
                regs_q[i] <= i_regfile_rd0_data;
            end
        end
    end

    function automatic logic [XLEN-1:0] rd(input logic [4:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        if (!in_range(a) || state_q != S_READY) begin
            v = '0;
        end else if (BYPASS && we1 && i_regfile_rd1_addr == a) begin
            v = i_regfile_rd1_data;
        end else if (BYPASS && we0 && i_regfile_rd0_addr == a) begin
            v = i_regfile_rd0_data;
        end else begin
            v = regs_q[a[AW-1:0]];
        end
        return v;
    endfunction

    always_comb begin
        o_regfile_rs1_data = rd(i_regfile_rs1_addr);
    end

    always_comb begin
        o_regfile_rs2_data = rd(i_regfile_rs2_addr);
    end

    assign o_regfile_ready = (state_q == S_READY);

endmodule

// File: tb/tb_riscv_regfile_2w2r.sv
// Scoreboard bench: three builds (default, no-bypass, RV32E) share stimulus;
// expected values are queued by the stimulus and checked by a negedge monitor.
module tb_riscv_regfile_2w2r;

    logic        clk;
    logic        rst;
    logic        wen0, wen1;
    logic [4:0]  wa0, wa1, ra1, ra2;
    logic [31:0] wd0, wd1;
    logic [31:0] rs1_a, rs2_a, rs1_b, rs2_b, rs1_c, rs2_c;
    logic        rdy_a, rdy_b, rdy_c;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        string       name;
        int          cyc;
        int          dut;
        int          port;
        logic [31:0] exp;
    } item_t;

    item_t sb[$];

    riscv_regfile_2w2r #(
        .XLEN(32), .NREG(32), .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1)
    ) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_regfile_rd0_wen(wen0), .i_regfile_rd0_addr(wa0),
        .i_regfile_rd0_data(wd0),
        .i_regfile_rd1_wen(wen1), .i_regfile_rd1_addr(wa1),
        .i_regfile_rd1_data(wd1),
        .i_regfile_rs1_addr(ra1), .i_regfile_rs2_addr(ra2),
        .o_regfile_rs1_data(rs1_a), .o_regfile_rs2_data(rs2_a),
        .o_regfile_ready(rdy_a)
    );

    riscv_regfile_2w2r #(
        .XLEN(32), .NREG(32), .BYPASS(1'b0), .CLEAR_ON_RESET(1'b1)
    ) u_nb (
        .i_clk(clk), .i_rst(rst),
        .i_regfile_rd0_wen(wen0), .i_regfile_rd0_addr(wa0),
        .i_regfile_rd0_data(wd0),
        .i_regfile_rd1_wen(wen1), .i_regfile_rd1_addr(wa1),
        .i_regfile_rd1_data(wd1),
        .i_regfile_rs1_addr(ra1), .i_regfile_rs2_addr(ra2),
        .o_regfile_rs1_data(rs1_b), .o_regfile_rs2_data(rs2_b),
        .o_regfile_ready(rdy_b)
    );

    riscv_regfile_2w2r #(
        .XLEN(32), .NREG(16), .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1)
    ) u_e (
        .i_clk(clk), .i_rst(rst),
        .i_regfile_rd0_wen(wen0), .i_regfile_rd0_addr(wa0),
        .i_regfile_rd0_data(wd0),
        .i_regfile_rd1_wen(wen1), .i_regfile_rd1_addr(wa1),
        .i_regfile_rd1_data(wd1),
        .i_regfile_rs1_addr(ra1), .i_regfile_rs2_addr(ra2),
        .o_regfile_rs1_data(rs1_c), .o_regfile_rs2_data(rs2_c),
        .o_regfile_ready(rdy_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    function automatic logic [31:0] get_act(input int dut, input int port);
        logic [31:0] v;
        v = '0;
        case (dut)
            0: v = (port == 0) ? rs1_a : (port == 1) ? rs2_a : {31'b0, rdy_a};
            1: v = (port == 0) ? rs1_b : (port == 1) ? rs2_b : {31'b0, rdy_b};
            default: v = (port == 0) ? rs1_c : (port == 1) ? rs2_c : {31'b0, rdy_c};
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        item_t       it;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it  = sb.pop_front();
            act = get_act(it.dut, it.port);
            checks++;
            if (act !== it.exp) begin
                errors++;
                $display("FAIL %s (dut%0d port%0d): got %h expected %h",
                         it.name, it.dut, it.port, act, it.exp);
            end
        end
    end

    task automatic chk(input string n, input int dut, input int port,
                       input logic [31:0] exp);
        item_t it;
        it.name = n;
        it.cyc  = cyc;
        it.dut  = dut;
        it.port = port;
        it.exp  = exp;
        sb.push_back(it);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wr();
        wen0 = 1'b0; wa0 = '0; wd0 = '0;
        wen1 = 1'b0; wa1 = '0; wd1 = '0;
    endtask

    initial begin
        idle_wr();
        ra1 = '0;
        ra2 = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // T1: clear sequence length and zeroed contents
        for (int k = 0; k < 32; k++) begin
            ra1 = 5'(k);
            ra2 = 5'(31 - k);
            chk("t1_rdy", 0, 2, 32'(k >= 31));
            chk("t1_rdy_nb", 1, 2, 32'(k >= 31));
            chk("t1_rdy_e", 2, 2, 32'(k >= 15));
            chk("t1_rs1", 0, 0, 32'h0);
            chk("t1_rs2", 0, 1, 32'h0);
            chk("t1_rs1_e", 2, 0, 32'h0);
            tick();
        end

        // T2: simple write then read; bypass visible same cycle
        wen0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        ra1 = 5'd5; ra2 = 5'd0;
        chk("t2_byp", 0, 0, 32'hDEADBEEF);
        chk("t2_nobyp", 1, 0, 32'h0);
        tick();
        idle_wr();
        chk("t2_rd", 0, 0, 32'hDEADBEEF);
        chk("t2_x0", 0, 1, 32'h0);
        chk("t2_rd_nb", 1, 0, 32'hDEADBEEF);
        chk("t2_rd_e", 2, 0, 32'hDEADBEEF);
        tick();

        // T3: same-address dual write, port 1 wins
        wen0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        wen1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        ra1 = 5'd7; ra2 = 5'd7;
        chk("t3_byp", 0, 0, 32'h22);
        chk("t3_byp2", 0, 1, 32'h22);
        chk("t3_nobyp", 1, 0, 32'h0);
        tick();
        idle_wr();
        chk("t3_rs1", 0, 0, 32'h22);
        chk("t3_rs2", 0, 1, 32'h22);
        chk("t3_nb", 1, 0, 32'h22);
        chk("t3_e", 2, 1, 32'h22);
        tick();

        // T4: no-bypass build sees the write one cycle later
        wen0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA5;
        ra1 = 5'd3; ra2 = 5'd5;
        chk("t4_old", 1, 0, 32'h0);
        chk("t4_byp", 0, 0, 32'hA5);
        tick();
        idle_wr();
        chk("t4_new", 1, 0, 32'hA5);
        chk("t4_x5", 1, 1, 32'hDEADBEEF);
        tick();

        // T5: RV32E drops out-of-range writes; x0 writes dropped everywhere
        wen0 = 1'b1; wa0 = 5'd4; wd0 = 32'h44;
        wen1 = 1'b1; wa1 = 5'd9; wd1 = 32'h99;
        tick();
        idle_wr();
        wen1 = 1'b1; wa1 = 5'd20; wd1 = 32'h1234;
        wen0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFF;
        ra1 = 5'd20; ra2 = 5'd4;
        chk("t5_e_oor", 2, 0, 32'h0);
        chk("t5_e_x4", 2, 1, 32'h44);
        chk("t5_byp20", 0, 0, 32'h1234);
        tick();
        idle_wr();
        chk("t5_e_oor2", 2, 0, 32'h0);
        chk("t5_e_x4b", 2, 1, 32'h44);
        chk("t5_x20", 0, 0, 32'h1234);
        tick();
        ra1 = 5'd0; ra2 = 5'd9;
        chk("t5_x0", 0, 0, 32'h0);
        chk("t5_x0_e", 2, 0, 32'h0);
        chk("t5_x9", 0, 1, 32'h99);
        chk("t5_x9_e", 2, 1, 32'h99);
        tick();

        // T6: reset in the 10th CLEAR cycle restarts the sequence
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk("t6_rdy_a", 0, 2, 32'h0);
            tick();
        end
        rst = 1'b1;
        chk("t6_rdy_rst", 0, 2, 32'h0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k == 0) begin
                wen0 = 1'b1; wa0 = 5'd12; wd0 = 32'h77;
                ra1 = 5'd12; ra2 = 5'd7;
                chk("t6_clr_rd", 0, 0, 32'h0);
                chk("t6_clr_rd_e", 2, 0, 32'h0);
            end else begin
                idle_wr();
            end
            chk("t6_rdy", 0, 2, 32'(k >= 31));
            chk("t6_rdy_e", 2, 2, 32'(k >= 15));
            tick();
        end
        ra1 = 5'd12; ra2 = 5'd5;
        chk("t6_x12", 0, 0, 32'h0);
        chk("t6_x5", 0, 1, 32'h0);
        chk("t6_x12_e", 2, 0, 32'h0);
        tick();
        ra1 = 5'd7; ra2 = 5'd9;
        chk("t6_x7", 0, 0, 32'h0);
        chk("t6_x9", 1, 1, 32'h0);
        tick();

        repeat (2) tick();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
